// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile mixer: resolution table, layout modes, config FSM states.
package vga_pkg;

    localparam int unsigned RES_W = 4;
    localparam int unsigned HV_W  = 16;

    localparam logic [RES_W-1:0] RES_640X480   = 4'd0;
    localparam logic [RES_W-1:0] RES_800X600   = 4'd1;
    localparam logic [RES_W-1:0] RES_1024X768  = 4'd2;
    localparam logic [RES_W-1:0] RES_1280X720  = 4'd3;
    localparam logic [RES_W-1:0] RES_1280X1024 = 4'd4;
    localparam logic [RES_W-1:0] RES_1280X800  = 4'd5;
    localparam logic [RES_W-1:0] RES_1366X768  = 4'd6;
    localparam logic [RES_W-1:0] RES_1920X1080 = 4'd7;

    typedef enum logic [1:0] {
        MODE_GRID    = 2'd0,
        MODE_VSTRIPE = 2'd1,
        MODE_HBAND   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_DIV_H = 2'd0,
        ST_DIV_V = 2'd1,
        ST_BOUND = 2'd2,
        ST_READY = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic [RES_W-1:0] res;
        mode_e            mode;
    } cfg_t;

    function automatic logic res_ok(input logic [RES_W-1:0] res);
        return res <= RES_1920X1080;
    endfunction

    function automatic logic [HV_W-1:0] h_active(input logic [RES_W-1:0] res);
        case (res)
            RES_640X480:   return 16'd640;
            RES_800X600:   return 16'd800;
            RES_1024X768:  return 16'd1024;
            RES_1280X720:  return 16'd1280;
            RES_1280X1024: return 16'd1280;
            RES_1280X800:  return 16'd1280;
            RES_1366X768:  return 16'd1366;
            RES_1920X1080: return 16'd1920;
            default:       return 16'd0;
        endcase
    endfunction

    function automatic logic [HV_W-1:0] v_active(input logic [RES_W-1:0] res);
        case (res)
            RES_640X480:   return 16'd480;
            RES_800X600:   return 16'd600;
            RES_1024X768:  return 16'd768;
            RES_1280X720:  return 16'd720;
            RES_1280X1024: return 16'd1024;
            RES_1280X800:  return 16'd800;
            RES_1366X768:  return 16'd768;
            RES_1920X1080: return 16'd1080;
            default:       return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_tile_mixer_if.sv
// Pixel stream between the VGA timing generator (master) and the tile mixer (slave).
interface vga_tile_mixer_if #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned COLOR_W = 24
);
    logic                   px_valid;
    logic [COORD_W-1:0]     px_h;
    logic [COORD_W-1:0]     px_v;
    logic                   px_valid_out;
    logic [COLOR_W-1:0]     px_24bit_data;
    logic [COLOR_W/2-1:0]   px_12bit_data;

    modport master (
        output px_valid, px_h, px_v,
        input  px_valid_out, px_24bit_data, px_12bit_data
    );

    modport slave (
        input  px_valid, px_h, px_v,
        output px_valid_out, px_24bit_data, px_12bit_data
    );
endinterface

// File: rtl/vga_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle; a new start reloads even while busy.
module vga_seq_div #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [W-1:0]     q_q;
    logic [W-1:0]     d_q;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [W:0]       r_sh_c;
    logic             ge_c;

    assign r_sh_c   = {r_q, q_q[W-1]};
    assign ge_c     = r_sh_c >= {1'b0, d_q};
    assign quotient = q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q_q    <= dividend;
                d_q    <= divisor;
                r_q    <= '0;
                cnt_q  <= CNT_W'(W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                r_q   <= ge_c ? W'(r_sh_c - {1'b0, d_q}) : W'(r_sh_c);
                q_q   <= {q_q[W-2:0], ge_c};
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/vga_tile_mixer.sv
// Maps each pixel coordinate to one of COLS*ROWS colour channels using run-time
// selectable layouts; tile geometry is recomputed whenever resolution or mode changes.
module vga_tile_mixer
    import vga_pkg::*;
#(
    parameter int unsigned COLS    = 2,
    parameter int unsigned ROWS    = 2,
    parameter int unsigned COLOR_W = 24,
    parameter int unsigned COORD_W = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COLS*ROWS*COLOR_W-1:0] ch_data,
    input  logic [3:0]                   resolution,
    input  logic [1:0]                   mode,
    vga_tile_mixer_if.slave              px,
    output logic                         cfg_ready,
    output logic                         cfg_error
);
    localparam int unsigned CH_NUM = COLS * ROWS;
    localparam int unsigned IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned CNT_W  = $clog2(CH_NUM + 1);
    localparam int unsigned BND_W  = COORD_W + CNT_W;
    localparam int unsigned PROD_W = IDX_W + CNT_W;
    localparam int unsigned CMP_W  = COLOR_W / 3;
    localparam int unsigned NIB_W  = COLOR_W / 6;

    cfg_t               in_q, cfg_q, cfg_d;
    cfg_state_e         state_q, state_d;
    logic               go_q, go_d;
    logic               div_start_c, div_sel_v_c, div_done;
    logic [COORD_W-1:0] div_num_c, div_den_c, div_quot;
    logic [COORD_W-1:0] h_act_c, v_act_c, tile_w_q, tile_h_q;
    logic [CNT_W-1:0]   cols_eff_c, rows_eff_c;
    logic [BND_W-1:0]   bound_h_q [CH_NUM];
    logic [BND_W-1:0]   bound_v_q [CH_NUM];
    logic [BND_W-1:0]   acc_h_q, acc_v_q;
    logic [IDX_W-1:0]   bidx_q;
    logic [COLOR_W-1:0] bank_q [CH_NUM];

    logic [IDX_W-1:0]   col_c, row_c, s1_col, s1_row, idx_c;
    logic               black_c, s1_black, s1_valid;
    logic [COLOR_W-1:0] pix_c;
    logic [COLOR_W/2-1:0] pix12_c;

    // Active geometry and divider operands for the latched configuration
    always_comb begin
        h_act_c    = COORD_W'(h_active(cfg_q.res));
        v_act_c    = COORD_W'(v_active(cfg_q.res));
        cols_eff_c = CNT_W'(COLS);
        rows_eff_c = CNT_W'(ROWS);
        if (cfg_q.mode == MODE_VSTRIPE) begin
            cols_eff_c = CNT_W'(CH_NUM);
            rows_eff_c = CNT_W'(1);
        end else if (cfg_q.mode == MODE_HBAND) begin
            cols_eff_c = CNT_W'(1);
            rows_eff_c = CNT_W'(CH_NUM);
        end
        div_num_c = div_sel_v_c ? v_act_c : h_act_c;
        div_den_c = div_sel_v_c ? COORD_W'(rows_eff_c) : COORD_W'(cols_eff_c);
    end

    vga_seq_div #(.W(COORD_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (div_num_c),
        .divisor  (div_den_c),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Config FSM next state; a config mismatch always wins and re-arms the divider
    always_comb begin
        state_d     = state_q;
        go_d        = go_q;
        cfg_d       = cfg_q;
        div_start_c = 1'b0;
        div_sel_v_c = 1'b0;
        if (in_q != cfg_q) begin
            cfg_d   = in_q;
            state_d = ST_DIV_H;
            go_d    = 1'b1;
        end else begin
            case (state_q)
                ST_DIV_H: begin
                    if (go_q) begin
                        if (res_ok(cfg_q.res)) begin
                            div_start_c = 1'b1;
                            go_d        = 1'b0;
                        end
                    end else if (div_done) begin
                        div_start_c = 1'b1;
                        div_sel_v_c = 1'b1;
                        state_d     = ST_DIV_V;
                    end
                end
                ST_DIV_V: if (div_done) state_d = ST_BOUND;
                ST_BOUND: if (bidx_q == IDX_W'(CH_NUM - 1)) state_d = ST_READY;
                ST_READY: state_d = ST_READY;
                default:  state_d = ST_DIV_H;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_DIV_H;
            go_q      <= 1'b1;
            in_q      <= '0;
            cfg_q     <= '0;
            cfg_ready <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_q      <= go_d;
            in_q      <= '{res: resolution, mode: mode_e'(mode)};
            cfg_q     <= cfg_d;
            cfg_ready <= (state_d == ST_READY);
            cfg_error <= !res_ok(cfg_d.res);
        end
    end

    // Tile sizes and boundary accumulation, one boundary pair per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_w_q <= '0;
            tile_h_q <= '0;
            acc_h_q  <= '0;
            acc_v_q  <= '0;
            bidx_q   <= '0;
            for (int unsigned k = 0; k < CH_NUM; k++) begin
                bound_h_q[k] <= '0;
                bound_v_q[k] <= '0;
            end
        end else begin
            if (state_q == ST_DIV_H && state_d == ST_DIV_V) tile_w_q <= div_quot;
            if (state_q == ST_DIV_V && state_d == ST_BOUND) begin
                tile_h_q <= div_quot;
                acc_h_q  <= '0;
                acc_v_q  <= '0;
                bidx_q   <= '0;
            end
            if (state_q == ST_BOUND) begin
                bound_h_q[bidx_q] <= acc_h_q;
                bound_v_q[bidx_q] <= acc_v_q;
                acc_h_q <= acc_h_q + BND_W'(tile_w_q);
                acc_v_q <= acc_v_q + BND_W'(tile_h_q);
                bidx_q  <= bidx_q + IDX_W'(1);
            end
        end
    end

    // Colour bank only follows ch_data at frame start so a frame never mixes two palettes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < CH_NUM; c++) bank_q[c] <= '0;
        end else if (state_q != ST_READY ||
                     (px.px_valid && px.px_h == '0 && px.px_v == '0)) begin
            for (int unsigned c = 0; c < CH_NUM; c++) bank_q[c] <= ch_data[c*COLOR_W +: COLOR_W];
        end
    end

    // Stage 1: boundary compare; the last tile absorbs any remainder pixels
    always_comb begin
        col_c = '0;
        row_c = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            if (CNT_W'(k) < cols_eff_c && BND_W'(px.px_h) >= bound_h_q[k]) col_c = IDX_W'(k);
            if (CNT_W'(k) < rows_eff_c && BND_W'(px.px_v) >= bound_v_q[k]) row_c = IDX_W'(k);
        end
        black_c = !cfg_ready || px.px_h >= h_act_c || px.px_v >= v_act_c;
    end

    // Stage 2: channel select and 12-bit reduction
    always_comb begin
        idx_c = '0;
        if (cfg_q.mode == MODE_CHECKER) begin
            if (CH_NUM > 1) idx_c = IDX_W'(s1_row[0] ^ s1_col[0]);
        end else begin
            idx_c = IDX_W'(PROD_W'(s1_row) * PROD_W'(cols_eff_c) + PROD_W'(s1_col));
        end
        pix_c   = s1_black ? '0 : bank_q[idx_c];
        pix12_c = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            pix12_c[c*NIB_W +: NIB_W] = pix_c[c*CMP_W + CMP_W - NIB_W +: NIB_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid         <= 1'b0;
            s1_col           <= '0;
            s1_row           <= '0;
            s1_black         <= 1'b1;
            px.px_valid_out  <= 1'b0;
            px.px_24bit_data <= '0;
            px.px_12bit_data <= '0;
        end else begin
            s1_valid         <= px.px_valid;
            s1_col           <= col_c;
            s1_row           <= row_c;
            s1_black         <= black_c;
            px.px_valid_out  <= s1_valid;
            px.px_24bit_data <= pix_c;
            px.px_12bit_data <= pix12_c;
        end
    end
endmodule
